// File: rtl/rng_out_buffer_if.sv
// Read-side handshake between the random-word buffer and its consumers.
// master is the buffer, which drives the data and status; slave is a consumer, which drives data_re.
interface rng_out_buffer_if #(
    parameter int DEPTH_LOG = 4
);
    logic [15:0]        data_out;
    logic               data_valid;
    logic               data_re;
    logic               full;
    logic [DEPTH_LOG:0] count;
    logic               overflow;

    modport master (
        output data_out,
        output data_valid,
        output full,
        output count,
        output overflow,
        input  data_re
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  full,
        input  count,
        input  overflow,
        output data_re
    );
endinterface

// File: rtl/rng_out_buffer.sv
// Packs raw entropy bits into 16-bit words (first bit into the MSB).
// Queues the words in a first-word-fall-through FIFO that consumers read through rd.
module rng_out_buffer #(
    parameter int DEPTH_LOG = 4
) (
    input  logic                  clk,
    input  logic                  rst_x,
    input  logic                  stop,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    rng_out_buffer_if.master      rd
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG + 1)'(DEPTH);

    logic [14:0]          shreg;
    logic [3:0]           bcnt;
    logic [15:0]          mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [DEPTH_LOG:0]   cnt;
    logic                 ovf;

    logic        accept;
    logic        word_done;
    logic [15:0] word;
    logic        not_empty;
    logic        is_full;
    logic        pop;
    logic        wr_en;

    assign accept    = bit_valid & ~stop;
    assign word_done = accept & (bcnt == 4'd15);
    assign word      = {shreg, bit_in};
    assign not_empty = (cnt != '0);
    assign is_full   = (cnt == DEPTH_CNT);
    assign pop       = rd.data_re & not_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the word.
    assign wr_en     = word_done & (~is_full | pop);

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            shreg <= '0;
            bcnt  <= '0;
        end else if (accept) begin
            shreg <= word[14:0];
            bcnt  <= bcnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (!wr_en && pop) begin
                cnt <= cnt - 1'b1;
            end
            if (word_done && !wr_en) begin
                ovf <= 1'b1;
            end
        end
    end

    assign rd.data_out   = not_empty ? mem[rd_ptr] : 16'h0000;
    assign rd.data_valid = not_empty;
    assign rd.full       = is_full;
    assign rd.count      = cnt;
    assign rd.overflow   = ovf;
endmodule

// File: tb/tb_rng_out_buffer.sv
// Self-checking bench for rng_out_buffer: vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_rng_out_buffer;
    logic clk = 1'b0;
    logic rst_x;
    logic stop;
    logic bit_in;
    logic bit_valid;

    rng_out_buffer_if #(.DEPTH_LOG(4)) rif ();

    rng_out_buffer #(.DEPTH_LOG(4)) dut (
        .clk       (clk),
        .rst_x     (rst_x),
        .stop      (stop),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .rd        (rif.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a queue of words, a partial word and its bit count.
    logic [15:0] mq[$];
    logic [15:0] m_part;
    int          m_nbits;
    bit          m_ovf;

    typedef struct {
        logic        s;
        logic        bv;
        logic        bi;
        logic        re;
        logic [15:0] d;
        logic        v;
        logic [4:0]  c;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_part  = 16'h0;
        m_nbits = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic bv, input logic bi, input logic re);
        if (re && mq.size() != 0) void'(mq.pop_front());
        if (bv && !s) begin
            m_part = {m_part[14:0], bi};
            m_nbits++;
            if (m_nbits == 16) begin
                if (mq.size() < 16) mq.push_back(m_part);
                else m_ovf = 1'b1;
                m_nbits = 0;
                m_part  = 16'h0;
            end
        end
    endtask

    task automatic cyc(input logic s, input logic bv, input logic bi, input logic re);
        stop = s; bit_valid = bv; bit_in = bi; rif.data_re = re;
        @(posedge clk);
        #1;
        model_edge(s, bv, bi, re);
        stop = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; rif.data_re = 1'b0;
    endtask

    task automatic do_reset();
        stop = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; rif.data_re = 1'b0;
        rst_x = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_x = 1'b1;
    endtask

    task automatic send_word(input logic [15:0] w, input logic re_last);
        for (int i = 15; i >= 0; i--) cyc(1'b0, 1'b1, w[i], (i == 0) ? re_last : 1'b0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_data"},  rif.data_out,   (mq.size() != 0) ? mq[0] : 16'h0);
        chk({tag, "_valid"}, rif.data_valid, mq.size() != 0);
        chk({tag, "_count"}, rif.count,      mq.size());
        chk({tag, "_full"},  rif.full,       mq.size() == 16);
        chk({tag, "_ovf"},   rif.overflow,   m_ovf);
    endtask

    initial begin
        int max_cnt;
        logic [15:0] w;
        vec_t r;

        // Basic packing: 1,0,1,0... gives 0xAAAA after the 16th bit, then one read empties.
        for (int i = 0; i < 16; i++) begin
            r = '{s: 1'b0, bv: 1'b1, bi: (i % 2 == 0), re: 1'b0,
                  d: (i == 15) ? 16'hAAAA : 16'h0, v: (i == 15), c: (i == 15) ? 5'd1 : 5'd0};
            tbl.push_back(r);
        end
        tbl.push_back('{s: 1'b0, bv: 1'b0, bi: 1'b0, re: 1'b1, d: 16'h0, v: 1'b0, c: 5'd0});
        // STOP mid-word: 8 ones, 5 frozen cycles offering zeros, 8 zeros -> 0xFF00.
        for (int i = 0; i < 8; i++)
            tbl.push_back('{s: 1'b0, bv: 1'b1, bi: 1'b1, re: 1'b0, d: 16'h0, v: 1'b0, c: 5'd0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{s: 1'b1, bv: 1'b1, bi: 1'b0, re: 1'b0, d: 16'h0, v: 1'b0, c: 5'd0});
        for (int i = 0; i < 8; i++) begin
            r = '{s: 1'b0, bv: 1'b1, bi: 1'b0, re: 1'b0,
                  d: (i == 7) ? 16'hFF00 : 16'h0, v: (i == 7), c: (i == 7) ? 5'd1 : 5'd0};
            tbl.push_back(r);
        end
        tbl.push_back('{s: 1'b0, bv: 1'b0, bi: 1'b0, re: 1'b1, d: 16'h0, v: 1'b0, c: 5'd0});

        do_reset();
        chk("rst_data",  rif.data_out,   16'h0);
        chk("rst_valid", rif.data_valid, 1'b0);
        chk("rst_full",  rif.full,       1'b0);
        chk("rst_count", rif.count,      5'd0);
        chk("rst_ovf",   rif.overflow,   1'b0);

        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].bv, tbl[i].bi, tbl[i].re);
            chk($sformatf("tbl%0d_data", i),  rif.data_out,   tbl[i].d);
            chk($sformatf("tbl%0d_valid", i), rif.data_valid, tbl[i].v);
            chk($sformatf("tbl%0d_count", i), rif.count,      tbl[i].c);
        end

        // Fill and overflow.
        do_reset();
        for (int i = 1; i <= 16; i++) send_word(16'(i), 1'b0);
        chk("fill_full",  rif.full,     1'b1);
        chk("fill_count", rif.count,    5'd16);
        chk("fill_ovf",   rif.overflow, 1'b0);
        send_word(16'hBEEF, 1'b0);
        chk("ovf_flag",  rif.overflow, 1'b1);
        chk("ovf_count", rif.count,    5'd16);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d", i), rif.data_out, 16'(i));
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("drain_valid", rif.data_valid, 1'b0);
        chk("drain_data",  rif.data_out,   16'h0);

        // Simultaneous pop and write at full.
        do_reset();
        for (int i = 1; i <= 16; i++) send_word(16'(i), 1'b0);
        send_word(16'h1234, 1'b1);
        chk("simul_count", rif.count,    5'd16);
        chk("simul_ovf",   rif.overflow, 1'b0);
        chk("simul_data",  rif.data_out, 16'h0002);
        w = 16'h0;
        for (int i = 0; i < 16; i++) begin
            w = rif.data_out;
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("simul_last", w, 16'h1234);
        chk("simul_empty", rif.data_valid, 1'b0);

        // Empty read is ignored, then 40 words read as they arrive (pointer wrap).
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("empty_count", rif.count,    5'd0);
        chk("empty_ovf",   rif.overflow, 1'b0);
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            w = 16'((i * 16'h0531) ^ 16'hC3A5);
            send_word(w, 1'b0);
            if (int'(rif.count) > max_cnt) max_cnt = int'(rif.count);
            chk($sformatf("wrap%0d", i), rif.data_out, w);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("wrap_maxcnt", max_cnt, 1);
        chk("wrap_empty",  rif.count, 5'd0);

        // Reset mid-operation: 3 queued, 7 bits into a 4th, OVERFLOW set.
        do_reset();
        for (int i = 1; i <= 17; i++) send_word(16'(i), 1'b0);
        for (int i = 0; i < 13; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_count", rif.count,    5'd3);
        chk("pre_rst_ovf",   rif.overflow, 1'b1);
        #2;
        rst_x = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_data",  rif.data_out,   16'h0);
        chk("mid_rst_valid", rif.data_valid, 1'b0);
        chk("mid_rst_full",  rif.full,       1'b0);
        chk("mid_rst_count", rif.count,      5'd0);
        chk("mid_rst_ovf",   rif.overflow,   1'b0);
        @(posedge clk);
        #1;
        rst_x = 1'b1;
        send_word(16'hFFFF, 1'b0);
        chk("post_rst_data",  rif.data_out, 16'hFFFF);
        chk("post_rst_count", rif.count,    5'd1);

        // Randomized traffic against the reference model, alternating fill-heavy and drain-heavy phases.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int re_pct;
            re_pct = ((i / 800) % 2 == 0) ? 2 : 50;
            cyc($urandom_range(99) < 10, $urandom_range(99) < 85,
                1'($urandom), $urandom_range(99) < re_pct);
            check_model("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rng_out_buffer.md
# rng_out_buffer

Producer side of the random-word read interface. Packs single raw random bits from the entropy source into 16-bit words and queues them in a small first-word-fall-through FIFO. Serves those words to downstream consumers (the statistics unit and the host-side reader) through a data/valid/read-enable handshake.

## Interface
- DEPTH_LOG, 4, log2 of FIFO depth in 16-bit words (depth = 2^DEPTH_LOG = 16)
- CLK  input  1  system clock; all state on rising edge
- RST_X  input  1  asynchronous active-low reset
- STOP  input  1  freeze bit collection; reads still served
- BIT_IN  input  1  raw random bit
- BIT_VALID  input  1  BIT_IN is valid this cycle
- DATA_OUT  output  16  head word of FIFO; 0 when empty
- DATA_VALID  output  1  FIFO not empty
- DATA_RE  input  1  consumer pops head word this cycle
- FULL  output  1  FIFO holds 2^DEPTH_LOG words
- COUNT  output  DEPTH_LOG+1  number of words held (0..16)
- OVERFLOW  output  1  sticky: a completed word was dropped because the FIFO was full

## Operation
- **Packing:**
  - 15-bit shift register SHREG and a 4-bit bit counter BCNT (0..15).
  - An accepted bit (BIT_VALID=1 and STOP=0) updates SHREG to {SHREG[13:0], BIT_IN}.
  - On BCNT<15, an accepted bit increments BCNT.
  - On BCNT=15, an accepted bit completes WORD = {SHREG[14:0], BIT_IN} and wraps BCNT to 0. The first-received bit lands in WORD[15].
- **STOP=1:**
  - BIT_VALID is ignored.
  - SHREG and BCNT are retained, so a partial word resumes when STOP falls.
  - The FIFO, the read path and OVERFLOW are unaffected.
- **Write:**
  - A completed word is written at that same edge if COUNT<16.
  - If COUNT=16 and DATA_RE=1 in the same cycle, the write also succeeds: the pop frees a slot, and COUNT stays 16.
  - Otherwise the word is dropped and OVERFLOW is set to 1. The bit counter still wraps.
- **Read:**
  - A pop occurs on DATA_RE=1 and DATA_VALID=1. The read pointer advances and COUNT decrements.
  - DATA_RE with the FIFO empty is ignored: no pointer change, no error flag.
- **Simultaneous pop and write at any COUNT:** COUNT is unchanged and both pointers advance.
- **Pointers and outputs:**
  - Read and write pointers are DEPTH_LOG bits wide and wrap modulo 16.
  - COUNT is a separate counter, so full and empty are unambiguous.
- **OVERFLOW:** cleared only by reset.
- **Reset (any time, including mid-word or with data queued):**
  - SHREG=0, BCNT=0, pointers=0, COUNT=0, OVERFLOW=0.
  - Queued data is discarded; FIFO memory contents need not be cleared.
- **Reset values of outputs:** DATA_OUT=0, DATA_VALID=0, FULL=0, COUNT=0, OVERFLOW=0.

## Timing
- Bit-to-word latency: the word completed at edge N is visible on DATA_OUT, with DATA_VALID=1, from cycle N+1. This holds when the FIFO was empty.
- DATA_OUT, DATA_VALID, FULL and COUNT derive from registered state only. There is no combinational path from DATA_RE or BIT_IN to any output.
- The consumer samples DATA_OUT in the cycle it asserts DATA_RE. The next word, or 0 if now empty, appears the cycle after.
- Throughput:
  - Read: one word per cycle.
  - Write: one word per 16 accepted bits. At most one write per cycle.
- COUNT reflects both the write and the pop of edge N from cycle N+1.
- OVERFLOW rises in the cycle after the dropping edge.

## Test plan
- **Basic packing:**
  - Stimulus: reset, then 16 accepted bits 1,0,1,0,… (1 first).
  - Response: DATA_OUT=0xAAAA, DATA_VALID=1, COUNT=1 one cycle after the 16th bit. DATA_RE for one cycle gives DATA_VALID=0, DATA_OUT=0, COUNT=0.
- **STOP mid-word:**
  - Stimulus: 8 bits of 1, then STOP=1 for 5 cycles with BIT_VALID=1 and BIT_IN=0, then STOP=0 and 8 bits of 0.
  - Response: a single word 0xFF00 is queued.
- **Fill and overflow:**
  - Stimulus: write 16 words 0x0001..0x0010 with no reads.
  - Response: FULL=1, COUNT=16, OVERFLOW=0.
  - Stimulus: complete a 17th word 0xBEEF.
  - Response: OVERFLOW=1, COUNT=16. Draining 16 reads yields 0x0001..0x0010 in order, then DATA_VALID=0.
- **Simultaneous pop and write at full:**
  - Stimulus: FIFO full with 0x0001..0x0010; the 16th bit of 0x1234 arrives with DATA_RE=1.
  - Response: COUNT=16, OVERFLOW=0, DATA_OUT=0x0002 next cycle. The last word drained is 0x1234.
- **Empty read and pointer wrap:**
  - Stimulus: DATA_RE=1 with the FIFO empty.
  - Response: COUNT stays 0, no flag set.
  - Stimulus: 40 words, each read as it arrives.
  - Response: all 40 returned in order, COUNT never exceeds 1.
- **Reset mid-operation:**
  - Stimulus: 3 words queued, 7 bits into a 4th, OVERFLOW=1; pulse RST_X low.
  - Response: all outputs at reset values immediately. After release, 16 bits of 1 produce exactly one word 0xFFFF with COUNT=1.
